// File: rtl/uart_rx_framer.sv
// uart_rx_framer: 16x oversampling UART receiver with a FIFO push port.
// Reports framing, parity and overrun events as one-cycle pulses.
module uart_rx_framer #(
  parameter int OVS   = 16,
  parameter int DBITS = 8,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             softreset,
  input  logic [15:0]      divisor,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic             rxd,
  output logic             validout,
  output logic [DBITS-1:0] dataout,
  input  logic             full,
  output logic             frame_err,
  output logic             parity_err,
  output logic             overrun,
  output logic [CNTW-1:0]  overrun_count,
  output logic             busy
);

  localparam int SCW = $clog2(OVS);
  localparam int BW  = $clog2(DBITS);
  localparam logic [SCW-1:0] MID  = SCW'(OVS / 2 - 1);
  localparam logic [SCW-1:0] LAST = SCW'(OVS - 1);
  localparam logic [BW-1:0]  BLST = BW'(DBITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAITHI
  } state_t;

  state_t           state;
  logic             clr;
  logic             s1;
  logic             s2;
  logic             prev;
  logic             rxs;
  logic             det;
  logic             tick;
  logic [15:0]      divcnt;
  logic [15:0]      div_lat;
  logic [SCW-1:0]   sc;
  logic [BW-1:0]    bidx;
  logic [DBITS-1:0] shreg;
  logic             perr;

  assign clr  = !rst_n || softreset;
  assign rxs  = s2;
  assign det  = (state == IDLE) && !rxs && prev;
  assign tick = (divcnt == div_lat);

  // Two-flop synchronizer plus previous-sample register for edge detect
  always_ff @(posedge clk) begin
    if (clr) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= rxd;
      s2   <= s1;
      prev <= s2;
    end
  end

  // Tick divider; divisor is latched only when the counter reloads
  always_ff @(posedge clk) begin
    if (clr) begin
      divcnt  <= '0;
      div_lat <= divisor;
    end else if (det || tick) begin
      divcnt  <= '0;
      div_lat <= divisor;
    end else begin
      divcnt  <= divcnt + 16'd1;
    end
  end

  // Receive FSM with registered push and error pulses
  always_ff @(posedge clk) begin
    if (clr) begin
      state         <= IDLE;
      sc            <= '0;
      bidx          <= '0;
      shreg         <= '0;
      perr          <= 1'b0;
      validout      <= 1'b0;
      dataout       <= '0;
      frame_err     <= 1'b0;
      parity_err    <= 1'b0;
      overrun       <= 1'b0;
      overrun_count <= '0;
      busy          <= 1'b0;
    end else begin
      validout   <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
      if (tick) sc <= sc + SCW'(1);
      unique case (state)
        IDLE: begin
          if (det) begin
            sc    <= '0;
            perr  <= 1'b0;
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (tick && sc == MID) begin
            if (rxs) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              sc    <= '0;
              bidx  <= '0;
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick && sc == LAST) begin
            shreg <= {rxs, shreg[DBITS-1:1]};
            bidx  <= bidx + BW'(1);
            if (bidx == BLST)
              state <= parity_en ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tick && sc == LAST) begin
            perr  <= (^shreg) ^ rxs ^ parity_odd;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick && sc == LAST) begin
            if (!rxs) begin
              frame_err <= 1'b1;
              state     <= WAITHI;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
              if (perr) begin
                parity_err <= 1'b1;
              end else if (full) begin
                overrun <= 1'b1;
                if (overrun_count != '1)
                  overrun_count <= overrun_count + CNTW'(1);
              end else begin
                validout <= 1'b1;
                dataout  <= shreg;
              end
            end
          end
        end
        WAITHI: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: directed bench with a byte scoreboard.
// Drives serial frames and checks pushes and error pulses.
module tb_uart_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        softreset;
  logic [15:0] divisor;
  logic        parity_en;
  logic        parity_odd;
  logic        rxd;
  logic        full;
  logic        validout;
  logic [7:0]  dataout;
  logic        frame_err;
  logic        parity_err;
  logic        overrun;
  logic [15:0] overrun_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int npush = 0;
  int fe_n = 0;
  int pe_n = 0;
  int ov_n = 0;
  logic [7:0] sb[$];
  int push_cyc[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_framer dut (
    .clk(clk),
    .rst_n(rst_n),
    .softreset(softreset),
    .divisor(divisor),
    .parity_en(parity_en),
    .parity_odd(parity_odd),
    .rxd(rxd),
    .validout(validout),
    .dataout(dataout),
    .full(full),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun),
    .overrun_count(overrun_count),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every push must match the oldest expected byte
  always @(negedge clk) begin
    if (validout) begin
      logic [7:0] e;
      npush++;
      push_cyc.push_back(cyc);
      chk("push_while_full", {31'd0, full}, 32'd0);
      chk("push_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("push_data", {24'd0, dataout}, {24'd0, e});
      end
    end
    if (frame_err) fe_n++;
    if (parity_err) pe_n++;
    if (overrun) ov_n++;
  end

  task automatic send(input logic [7:0] b, input bit pen, input bit pbit,
                      input bit stopb, input int p);
    rxd = 1'b0;
    fall_cyc = cyc;
    repeat (16 * p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (16 * p) @(negedge clk);
    end
    if (pen) begin
      rxd = pbit;
      repeat (16 * p) @(negedge clk);
    end
    rxd = stopb;
    repeat (16 * p) @(negedge clk);
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_validout"}, {31'd0, validout}, 32'd0);
    chk({tag, "_dataout"}, {24'd0, dataout}, 32'd0);
    chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    chk({tag, "_parity_err"}, {31'd0, parity_err}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, overrun}, 32'd0);
    chk({tag, "_ovcount"}, {16'd0, overrun_count}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int d;
    int fe0;
    int pe0;
    int ov0;
    int np0;
    rst_n = 1'b0;
    softreset = 1'b0;
    divisor = 16'd0;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    rxd = 1'b1;
    full = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outs("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 good byte with latency check
    push_cyc.delete();
    sb.push_back(8'hA5);
    send(8'hA5, 0, 0, 1, 1);
    repeat (20) @(negedge clk);
    chk("t1_sb_empty", sb.size(), 32'd0);
    chk("t1_npush", push_cyc.size(), 32'd1);
    d = (push_cyc.size() > 0) ? push_cyc[0] - fall_cyc : -1;
    chk("t1_latency", {31'd0, (d == 155) || (d == 156)}, 32'd1);
    chk("t1_no_err", fe_n + pe_n + ov_n, 32'd0);
    chk("t1_hold", {24'd0, dataout}, 32'hA5);

    // Back-to-back frames at divisor 3
    divisor = 16'd3;
    push_cyc.delete();
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h3C);
    send(8'h00, 0, 0, 1, 4);
    send(8'hFF, 0, 0, 1, 4);
    send(8'h3C, 0, 0, 1, 4);
    repeat (40) @(negedge clk);
    chk("t2_sb_empty", sb.size(), 32'd0);
    chk("t2_npush", push_cyc.size(), 32'd3);
    if (push_cyc.size() == 3) begin
      chk("t2_gap01", push_cyc[1] - push_cyc[0], 32'd640);
      chk("t2_gap12", push_cyc[2] - push_cyc[1], 32'd640);
    end

    // Parity: odd good, odd bad, even good
    divisor = 16'd1;
    parity_en = 1'b1;
    parity_odd = 1'b1;
    sb.push_back(8'h01);
    send(8'h01, 1, 0, 1, 2);
    repeat (20) @(negedge clk);
    chk("t3_odd_ok", sb.size(), 32'd0);
    pe0 = pe_n;
    np0 = npush;
    send(8'h01, 1, 1, 1, 2);
    repeat (20) @(negedge clk);
    chk("t3_perr_pulse", pe_n - pe0, 32'd1);
    chk("t3_perr_nopush", npush - np0, 32'd0);
    parity_odd = 1'b0;
    sb.push_back(8'h03);
    send(8'h03, 1, 0, 1, 2);
    repeat (20) @(negedge clk);
    chk("t3_even_ok", sb.size(), 32'd0);
    parity_en = 1'b0;

    // Framing error followed by a break
    divisor = 16'd0;
    fe0 = fe_n;
    np0 = npush;
    send(8'h55, 0, 0, 0, 1);
    repeat (500) @(negedge clk);
    chk("t4_busy_break", {31'd0, busy}, 32'd1);
    chk("t4_ferr_pulse", fe_n - fe0, 32'd1);
    rxd = 1'b1;
    repeat (6) @(negedge clk);
    chk("t4_busy_rel", {31'd0, busy}, 32'd0);
    chk("t4_nopush", npush - np0, 32'd0);

    // Overrun with full held high, then soft reset
    full = 1'b1;
    ov0 = ov_n;
    np0 = npush;
    send(8'h11, 0, 0, 1, 1);
    send(8'h22, 0, 0, 1, 1);
    send(8'h33, 0, 0, 1, 1);
    repeat (10) @(negedge clk);
    chk("t5_ov_pulses", ov_n - ov0, 32'd3);
    chk("t5_ov_count", {16'd0, overrun_count}, 32'd3);
    chk("t5_nopush", npush - np0, 32'd0);
    full = 1'b0;
    softreset = 1'b1;
    @(negedge clk);
    softreset = 1'b0;
    chk("t5_soft_count", {16'd0, overrun_count}, 32'd0);

    // Short glitch is a false start
    fe0 = fe_n;
    pe0 = pe_n;
    ov0 = ov_n;
    np0 = npush;
    repeat (4) @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_busy_detect", {31'd0, busy}, 32'd1);
    repeat (40) @(negedge clk);
    chk("t6_busy_end", {31'd0, busy}, 32'd0);
    chk("t6_no_pulse", (fe_n - fe0) + (pe_n - pe0) + (ov_n - ov0), 32'd0);
    chk("t6_nopush", npush - np0, 32'd0);

    // Reset in the middle of a data bit
    np0 = npush;
    rxd = 1'b0;
    repeat (16) @(negedge clk);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    chk("t7_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle_outs("t7_rst");
    rst_n = 1'b1;
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("t7_nopush", npush - np0, 32'd0);
    sb.push_back(8'h96);
    send(8'h96, 0, 0, 1, 1);
    repeat (10) @(negedge clk);
    chk("t7_sb_empty", sb.size(), 32'd0);
    chk("t7_data", {24'd0, dataout}, 32'h96);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
